multicycle_arm_controller: RTL and testbench

- Multicycle replacement for the single-cycle ARM control path.
- Sequences a shared-memory datapath: one memory port, one ALU, instruction register (IR), PC register. Uses a Moore FSM of 3–5 cycles per instruction.
- Contains:
  - the instruction decode for data-processing, memory and branch classes;
  - NZCV flag storage;
  - a condition check evaluated once per instruction.
- Sits between the IR and datapath select/enable inputs; the datapath supplies ALUFlags combinationally.

---
 rtl/multicycle_arm_controller_if.sv | 28 ++
 rtl/multicycle_arm_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_arm_controller.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_arm_controller_if.sv
// Control bundle between the multicycle ARM controller (master) and its datapath (slave).
interface multicycle_arm_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_arm_controller.sv
// Multicycle ARM control path: Moore FSM over a shared-memory datapath with NZCV storage
// and per-instruction predication. Define MEM_WAIT_EN to add mem_ready wait states.
module multicycle_arm_controller #(
  parameter int STATE_W = 4
) (
  input  logic clk,
  input  logic reset,
  multicycle_arm_controller_if.master ctrl
`ifdef MEM_WAIT_EN
  ,
  input  logic mem_ready
`endif
);
  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(4'd0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(4'd1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(4'd2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(4'd3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4'd4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(4'd5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(4'd6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(4'd7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(4'd8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(4'd9);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         flags_q, flags_d;
  logic               cond_ok_q, cond_ok_d;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       funct_i, funct_s;
  logic       unused_rn;

  assign cond      = ctrl.Instr[19:16];
  assign op        = ctrl.Instr[15:14];
  assign funct_i   = ctrl.Instr[13];
  assign cmd       = ctrl.Instr[12:9];
  assign funct_s   = ctrl.Instr[8];
  assign rd        = ctrl.Instr[3:0];
  assign unused_rn = ^ctrl.Instr[7:4];

  logic mem_rdy;
`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  function automatic logic cond_ex(input logic [3:0] cc, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cc)
      4'h0:    return z;
      4'h1:    return ~z;
      4'h2:    return c;
      4'h3:    return ~c;
      4'h4:    return n;
      4'h5:    return ~n;
      4'h6:    return v;
      4'h7:    return ~v;
      4'h8:    return c & ~z;
      4'h9:    return ~(c & ~z);
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return ~z & (n == v);
      4'hD:    return ~(~z & (n == v));
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [1:0] alu_dec;
  logic       cmd_known, cmd_cmp, cmd_arith;

  // Data-processing command decode; unknown commands add and never write back
  always_comb begin
    alu_dec   = 2'b00;
    cmd_known = 1'b0;
    cmd_cmp   = 1'b0;
    cmd_arith = 1'b0;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; cmd_known = 1'b1; cmd_arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; cmd_known = 1'b1; cmd_arith = 1'b1; end
      4'b0000: begin alu_dec = 2'b10; cmd_known = 1'b1; end
      4'b1100: begin alu_dec = 2'b11; cmd_known = 1'b1; end
      4'b1010: begin alu_dec = 2'b01; cmd_known = 1'b1; cmd_cmp = 1'b1; cmd_arith = 1'b1; end
      default: begin alu_dec = 2'b00; cmd_known = 1'b0; end
    endcase
  end

  // Predicate capture in DECODE and flag update on the edge leaving EXECR/EXECI
  always_comb begin
    flags_d   = flags_q;
    cond_ok_d = cond_ok_q;
    if (state_q == S_DECODE) begin
      cond_ok_d = cond_ex(cond, flags_q);
    end else begin
      cond_ok_d = cond_ok_q;
    end
    if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ok_q && (funct_s || cmd_cmp)) begin
      flags_d[3:2] = ctrl.ALUFlags[3:2];
      if (cmd_arith) begin
        flags_d[1:0] = ctrl.ALUFlags[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // State, flag and predicate registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct_i ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct_s ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  logic       pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] reg_src, alu_src_a, alu_src_b, result_src, alu_control;

  // Moore output decode; a write to R15 redirects RegWrite onto PCWrite
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    reg_src     = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:  alu_src_b = 2'b01;
      S_MEMREAD: adr_src   = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        if (rd == 4'd15) begin
          pc_write = cond_ok_q;
        end else begin
          reg_write = cond_ok_q;
        end
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        reg_src   = 2'b10;
        mem_write = cond_ok_q & mem_rdy;
      end
      S_EXECR: begin
        alu_src_b   = 2'b00;
        alu_control = alu_dec;
      end
      S_EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        if (rd == 4'd15) begin
          pc_write = cond_ok_q;
        end else begin
          reg_write = cond_ok_q & cmd_known & ~cmd_cmp;
        end
      end
      S_BRANCH: begin
        reg_src    = 2'b01;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ok_q;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign ctrl.PCWrite    = pc_write  & ~reset;
  assign ctrl.IRWrite    = ir_write  & ~reset;
  assign ctrl.RegWrite   = reg_write & ~reset;
  assign ctrl.MemWrite   = mem_write & ~reset;
  assign ctrl.AdrSrc     = adr_src;
  assign ctrl.RegSrc     = reg_src;
  assign ctrl.ALUSrcA    = alu_src_a;
  assign ctrl.ALUSrcB    = alu_src_b;
  assign ctrl.ResultSrc  = result_src;
  assign ctrl.ImmSrc     = op;
  assign ctrl.ALUControl = alu_control;
endmodule

// File: tb/tb_multicycle_arm_controller.sv
// Scoreboard bench for multicycle_arm_controller: per-cycle expected control vectors are
// queued with the stimulus and compared on the falling edge.
module tb_multicycle_arm_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] instr = 20'h0;
  logic [3:0]  alu_flags = 4'h0;
  logic [3:0]  exp_flags = 4'h0;
  int          n_checks = 0;
  int          n_fail = 0;
`ifdef MEM_WAIT_EN
  logic        mem_ready = 1'b1;
`endif

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  flags;
    logic [20:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];

  multicycle_arm_controller_if bus();
  assign bus.Instr    = instr;
  assign bus.ALUFlags = alu_flags;

  multicycle_arm_controller #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
`ifdef MEM_WAIT_EN
    ,
    .mem_ready (mem_ready)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [20:0] observe();
    return {dut.state_q, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
            bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl};
  endfunction

  function automatic logic [20:0] v(input logic [3:0] st, input logic pcw, input logic irw,
                                    input logic rw, input logic mw, input logic adr,
                                    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sbv,
                                    input logic [1:0] res, input logic [1:0] imm, input logic [1:0] alu);
    return {st, pcw, irw, rw, mw, adr, rs, sa, sbv, res, imm, alu};
  endfunction

  function automatic logic [20:0] xf(input logic [1:0] op);
    return v(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, op, 2'b00);
  endfunction
  function automatic logic [20:0] xd(input logic [1:0] op);
    return v(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, op, 2'b00);
  endfunction
  function automatic logic [20:0] xe(input logic imm, input logic [1:0] alu);
    return v(imm ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
             imm ? 2'b01 : 2'b00, 2'b00, 2'b00, alu);
  endfunction
  function automatic logic [20:0] xw(input logic pcw, input logic rw);
    return v(4'd8, pcw, 1'b0, rw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [20:0] xb(input logic pcw);
    return v(4'd9, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00);
  endfunction

  function automatic logic exp_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, vv;
    n = f[3]; z = f[2]; c = f[1]; vv = f[0];
    case (cc)
      4'h0: return z;          4'h1: return !z;
      4'h2: return c;          4'h3: return !c;
      4'h4: return n;          4'h5: return !n;
      4'h6: return vv;         4'h7: return !vv;
      4'h8: return c && !z;    4'h9: return !(c && !z);
      4'hA: return n == vv;    4'hB: return n != vv;
      4'hC: return !z && (n == vv);
      4'hD: return !(!z && (n == vv));
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [19:0] i, input logic [3:0] f, input logic [20:0] x, input string t);
    sb_t e;
    e.instr = i; e.flags = f; e.exp = x; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic push_dp(input logic [19:0] i, input logic [3:0] f, input logic imm,
                         input logic [1:0] alu, input logic pcw, input logic rw, input string t);
    push(i, 4'h0, xf(2'b00), {t, ".fetch"});
    push(i, 4'h0, xd(2'b00), {t, ".decode"});
    push(i, f,    xe(imm, alu), {t, ".exec"});
    push(i, 4'h0, xw(pcw, rw), {t, ".aluwb"});
  endtask

  task automatic push_br(input logic [19:0] i, input logic pcw, input string t);
    push(i, 4'h0, xf(2'b10), {t, ".fetch"});
    push(i, 4'h0, xd(2'b10), {t, ".decode"});
    push(i, 4'h0, xb(pcw),   {t, ".branch"});
  endtask

  task automatic push_mem(input logic [19:0] i, input logic ld, input logic pcw, input logic rw,
                          input logic mw, input string t);
    push(i, 4'h0, xf(2'b01), {t, ".fetch"});
    push(i, 4'h0, xd(2'b01), {t, ".decode"});
    push(i, 4'h0, v(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00),
         {t, ".memadr"});
    if (ld) begin
      push(i, 4'h0, v(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00),
           {t, ".memread"});
      push(i, 4'h0, v(4'd4, pcw, 1'b0, rw, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00),
           {t, ".memwb"});
    end else begin
      push(i, 4'h0, v(4'd5, 1'b0, 1'b0, 1'b0, mw, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00),
           {t, ".memwrite"});
    end
  endtask

  task automatic test_reset();
    logic [20:0] got;
    reset = 1'b1;
    instr = 20'h0;
    repeat (2) @(negedge clk);
    got = observe();
    n_checks++;
    if (got !== v(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00)) begin
      n_fail++;
      $display("FAIL reset.outputs: observed %h expected %h", got,
               v(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00));
    end
    n_checks++;
    if ({dut.flags_q, dut.cond_ok_q} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset.flags: observed %b expected 00000", {dut.flags_q, dut.cond_ok_q});
    end
    exp_flags = 4'h0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_fetch_add();
    sb_t e;
    logic [20:0] got;
    push_dp(20'hE0810, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1, "add");
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
  endtask

  task automatic test_flags_branch();
    sb_t e;
    logic [20:0] got;
    push_dp(20'hE0511, 4'b0100, 1'b0, 2'b01, 1'b0, 1'b1, "subs_z");
    push_br(20'h0A000, 1'b1, "beq_taken");
    push_dp(20'hE0511, 4'b0000, 1'b0, 2'b01, 1'b0, 1'b1, "subs_nz");
    push_br(20'h0A000, 1'b0, "beq_not");
    exp_flags = 4'b0000;
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
    n_checks++;
    if (dut.flags_q !== exp_flags) begin
      n_fail++;
      $display("FAIL flags_branch.nzcv: observed %b expected %b", dut.flags_q, exp_flags);
    end
  endtask

  task automatic test_load();
    sb_t e;
    logic [20:0] got;
    push_mem(20'hE591F, 1'b1, 1'b1, 1'b0, 1'b0, "ldr_pc");
    push_mem(20'hE5912, 1'b1, 1'b0, 1'b1, 1'b0, "ldr_r2");
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
  endtask

  task automatic test_store_cond();
    sb_t e;
    logic [20:0] got;
    push_dp(20'hE0511, 4'b0100, 1'b0, 2'b01, 1'b0, 1'b1, "subs_z");
    push_mem(20'h15800, 1'b0, 1'b0, 1'b0, 1'b0, "strne_fail");
    push_mem(20'hE5800, 1'b0, 1'b0, 1'b0, 1'b1, "str_al");
    exp_flags = 4'b0100;
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
  endtask

  task automatic test_cmp();
    sb_t e;
    logic [20:0] got;
    push_dp(20'hE1510, 4'b0110, 1'b0, 2'b01, 1'b0, 1'b0, "cmp");
    push_dp(20'h11510, 4'b1001, 1'b0, 2'b01, 1'b0, 1'b0, "cmpne_fail");
    exp_flags = 4'b0110;
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
    n_checks++;
    if (dut.flags_q !== exp_flags) begin
      n_fail++;
      $display("FAIL cmp.nzcv: observed %b expected %b", dut.flags_q, exp_flags);
    end
  endtask

  task automatic test_alu_decode();
    sb_t e;
    logic [20:0] got;
    push_dp(20'hE391F, 4'b1011, 1'b1, 2'b11, 1'b1, 1'b0, "orrs_imm_pc");
    push_dp(20'hE0114, 4'b0101, 1'b0, 2'b10, 1'b0, 1'b1, "ands");
    push_dp(20'hE0203, 4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, "unknown_cmd");
    exp_flags = 4'b0110;
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
    n_checks++;
    if (dut.flags_q !== exp_flags) begin
      n_fail++;
      $display("FAIL alu_decode.nzcv: observed %b expected %b", dut.flags_q, exp_flags);
    end
  endtask

  task automatic test_cond_codes();
    sb_t e;
    logic [20:0] got;
    logic [3:0] pats [4];
    logic [3:0] cc;
    pats[0] = 4'b0100; pats[1] = 4'b1001; pats[2] = 4'b0010; pats[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      push_dp(20'hE1510, pats[k], 1'b0, 2'b01, 1'b0, 1'b0, $sformatf("cmp_%b", pats[k]));
      for (int c = 0; c < 16; c++) begin
        cc = 4'(c);
        push_br({cc, 8'hA0, 8'h00}, exp_cond(cc, pats[k]), $sformatf("b_cond%h_nzcv%b", cc, pats[k]));
      end
      exp_flags = pats[k];
      instr = sb[0].instr;
      while (sb.size() != 0) begin
        @(negedge clk);
        e = sb.pop_front();
        got = observe();
        n_checks++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
        end
        alu_flags = e.flags;
        if (sb.size() != 0) instr = sb[0].instr;
      end
    end
  endtask

  task automatic test_reset_midop();
    sb_t e;
    logic [20:0] got;
    push_mem(20'hE5800, 1'b0, 1'b0, 1'b0, 1'b1, "str_pre_reset");
    instr = sb[0].instr;
    while (sb.size() != 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = observe();
      n_checks++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
      alu_flags = e.flags;
      if (sb.size() != 0) instr = sb[0].instr;
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset.memwrite: observed %b expected 0", bus.MemWrite);
    end
    n_checks++;
    if (dut.state_q !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset.state: observed %0d expected 0", dut.state_q);
    end
    n_checks++;
    if (dut.flags_q !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset.nzcv: observed %b expected 0000", dut.flags_q);
    end
    exp_flags = 4'h0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    instr = 20'hE0810;
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({dut.state_q, bus.IRWrite, bus.PCWrite} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL memwait.hold: observed %b expected 000000", {dut.state_q, bus.IRWrite, bus.PCWrite});
      end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({dut.state_q, bus.IRWrite, bus.PCWrite} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL memwait.ready: observed %b expected 000011", {dut.state_q, bus.IRWrite, bus.PCWrite});
    end
    @(negedge clk);
    n_checks++;
    if (dut.state_q !== 4'd1) begin
      n_fail++;
      $display("FAIL memwait.advance: observed %0d expected 1", dut.state_q);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_add();
    test_flags_branch();
    test_load();
    test_store_cond();
    test_cmp();
    test_alu_decode();
    test_cond_codes();
    test_reset_midop();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
